ras_stack_ctrl: RTL and testbench

RAS_STACK_CTRL -- requirements
Module: ras_stack_ctrl

---
 rtl/ras_pkg.sv | 18 +
 rtl/ras_stack_ctrl_bram.sv | 27 ++
 rtl/ras_stack_ctrl.sv | 153 +++++++++++++++
 tb/tb_ras_stack_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared types and defaults for the return-address-stack controller.
package ras_pkg;

    localparam int unsigned ADDR_DEFAULT  = 4;
    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        StInit   = 2'd0,
        StIdle   = 2'd1,
        StRefill = 2'd2
    } ras_state_e;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] data;
        logic [ADDR_DEFAULT-1:0]  link;
    } ras_node_t;

endpackage

// File: rtl/ras_stack_ctrl_bram.sv
// Simple dual-port RAM: one write port, one registered read port (latency 1).
module ras_stack_ctrl_bram #(
    parameter int unsigned ADDR  = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 36
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ADDR-1:0] waddr,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [ADDR-1:0] raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ras_stack_ctrl.sv
// Linked-list return-address stack: top entry cached in registers, remaining
// entries kept as {data, link} nodes in BRAM, nodes supplied by an external allocator.
module ras_stack_ctrl
    import ras_pkg::*;
#(
    parameter int unsigned ADDR  = ADDR_DEFAULT,
    parameter int unsigned DEPTH = 2 ** ADDR,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [ADDR:0]    count,
    output logic             empty,
    output logic             full,
    output logic             alloc,
    output logic             de_alloc,
    output logic [ADDR-1:0]  last_alloc_addr,
    output logic             alloc_reset,
    output logic [ADDR-1:0]  alloc_reset_addr,
    input  logic [ADDR-1:0]  alloc_addr
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [ADDR-1:0]  link;
    } node_t;

    localparam logic [ADDR:0] FullCnt = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR:0] OneCnt  = (ADDR + 1)'(1);

    ras_state_e       state_q, state_d;
    logic [ADDR:0]    count_q, count_d;
    logic [ADDR-1:0]  top_addr_q, top_addr_d;
    logic [WIDTH-1:0] top_data_q, top_data_d;
    logic [ADDR-1:0]  top_link_q, top_link_d;

    logic             mem_we;
    logic [ADDR-1:0]  mem_waddr;
    node_t            mem_wdata;
    logic             mem_re;
    logic [ADDR-1:0]  mem_raddr;
    node_t            mem_rdata;

    ras_stack_ctrl_bram #(
        .ADDR  (ADDR),
        .DEPTH (DEPTH),
        .DW    (WIDTH + ADDR)
    ) u_bram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign empty            = (count_q == '0);
    assign full             = (count_q == FullCnt);
    assign count            = count_q;
    assign pop_data         = top_data_q;
    assign last_alloc_addr  = top_addr_q;
    assign alloc_reset_addr = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StInit;
            count_q    <= '0;
            top_addr_q <= '0;
            top_data_q <= '0;
            top_link_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            top_addr_q <= top_addr_d;
            top_data_q <= top_data_d;
            top_link_q <= top_link_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        top_addr_d  = top_addr_q;
        top_data_d  = top_data_q;
        top_link_d  = top_link_q;
        ready       = 1'b0;
        alloc       = 1'b0;
        de_alloc    = 1'b0;
        pop_valid   = 1'b0;
        alloc_reset = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = alloc_addr;
        mem_wdata   = '0;
        mem_re      = 1'b0;
        mem_raddr   = top_link_q;

        // Outputs stay quiet while reset is held, even though state is already INIT.
        if (!rst) begin
            unique case (state_q)
                StInit: begin
                    alloc_reset = 1'b1;
                    state_d     = StIdle;
                end
                StIdle: begin
                    ready = 1'b1;
                    if (pop && !empty) begin
                        pop_valid = 1'b1;
                        if (push) begin
                            // Replace top in place: node keeps its address and link.
                            mem_we     = 1'b1;
                            mem_waddr  = top_addr_q;
                            mem_wdata  = '{data: push_data, link: top_link_q};
                            top_data_d = push_data;
                        end else begin
                            de_alloc = 1'b1;
                            count_d  = count_q - OneCnt;
                            if (count_q != OneCnt) begin
                                mem_re  = 1'b1;
                                state_d = StRefill;
                            end
                        end
                    end else if (push && !full) begin
                        alloc      = 1'b1;
                        mem_we     = 1'b1;
                        mem_waddr  = alloc_addr;
                        mem_wdata  = '{data: push_data, link: top_addr_q};
                        top_addr_d = alloc_addr;
                        top_data_d = push_data;
                        top_link_d = top_addr_q;
                        count_d    = count_q + OneCnt;
                    end
                end
                StRefill: begin
                    top_addr_d = top_link_q;
                    top_data_d = mem_rdata.data;
                    top_link_d = mem_rdata.link;
                    state_d    = StIdle;
                end
                default: begin
                    state_d = StInit;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ras_stack_ctrl.sv
// Directed bench for ras_stack_ctrl with a LIFO free-list allocator model.
module tb_ras_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [31:0] push_data = '0;
    logic [31:0] pop_data;
    logic        ready, pop_valid, empty, full, alloc, de_alloc, alloc_reset;
    logic [4:0]  count;
    logic [3:0]  last_alloc_addr, alloc_reset_addr;
    logic [3:0]  alloc_addr = '0;

    int checks = 0;
    int fails = 0;
    int alloc_cnt = 0;
    int areset_cnt = 0;

    logic [3:0] free_q[$];

    ras_stack_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .push             (push),
        .push_data        (push_data),
        .pop              (pop),
        .ready            (ready),
        .pop_data         (pop_data),
        .pop_valid        (pop_valid),
        .count            (count),
        .empty            (empty),
        .full             (full),
        .alloc            (alloc),
        .de_alloc         (de_alloc),
        .last_alloc_addr  (last_alloc_addr),
        .alloc_reset      (alloc_reset),
        .alloc_reset_addr (alloc_reset_addr),
        .alloc_addr       (alloc_addr)
    );

    always #5 clk = ~clk;

    // Allocator model: head of the free list is offered on alloc_addr.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q.delete();
            alloc_addr <= '0;
        end else begin
            if (alloc_reset) begin
                free_q.delete();
                for (int i = 0; i < 16; i++) free_q.push_back(4'(i));
            end else if (alloc) begin
                void'(free_q.pop_front());
            end else if (de_alloc) begin
                free_q.push_front(last_alloc_addr);
            end
            alloc_addr <= (free_q.size() > 0) ? free_q[0] : 4'd0;
            if (alloc) alloc_cnt <= alloc_cnt + 1;
            if (alloc_reset) areset_cnt <= areset_cnt + 1;
        end
    end

    task automatic step(input logic p, input logic [31:0] d, input logic q);
        @(negedge clk);
        push = p;
        push_data = d;
        pop = q;
        #1;
    endtask

    task automatic test_reset();
        int p0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", ready); end
        checks++; if (alloc_reset !== 1'b0) begin fails++; $display("FAIL rst_areset got %b want 0", alloc_reset); end
        checks++; if (alloc !== 1'b0 || de_alloc !== 1'b0 || pop_valid !== 1'b0) begin
            fails++; $display("FAIL rst_strobes got %b%b%b want 000", alloc, de_alloc, pop_valid); end
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (alloc_reset_addr !== 4'd0) begin fails++; $display("FAIL rst_raddr got %0d want 0", alloc_reset_addr); end
        @(negedge clk);
        rst = 1'b0;
        p0 = areset_cnt;
        #1;
        checks++; if (alloc_reset !== 1'b1) begin fails++; $display("FAIL init_areset got %b want 1", alloc_reset); end
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL init_ready got %b want 0", ready); end
        step(0, 0, 0);
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b want 1", ready); end
        checks++; if (alloc_reset !== 1'b0) begin fails++; $display("FAIL idle_areset got %b want 0", alloc_reset); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin
            fails++; $display("FAIL idle_count got %0d/%b want 0/1", count, empty); end
        step(0, 0, 0);
        checks++; if (areset_cnt - p0 != 1) begin fails++; $display("FAIL init_pulses got %0d want 1", areset_cnt - p0); end
    endtask

    task automatic test_push_pop();
        int a0;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h300; exp_d[1] = 32'h200; exp_d[2] = 32'h100;
        a0 = alloc_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h100 * (i + 1), 0);
            checks++; if (alloc !== 1'b1) begin fails++; $display("FAIL pp_alloc%0d got %b want 1", i, alloc); end
            checks++; if (alloc_addr !== 4'(i)) begin fails++; $display("FAIL pp_node%0d got %0d want %0d", i, alloc_addr, i); end
        end
        step(0, 0, 0);
        checks++; if (count !== 5'd3) begin fails++; $display("FAIL pp_count got %0d want 3", count); end
        checks++; if (alloc_cnt - a0 != 3) begin fails++; $display("FAIL pp_alloc_cycles got %0d want 3", alloc_cnt - a0); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            checks++; if (pop_valid !== 1'b1 || pop_data !== exp_d[i]) begin
                fails++; $display("FAIL pp_pop%0d got %b/%h want 1/%h", i, pop_valid, pop_data, exp_d[i]); end
            checks++; if (de_alloc !== 1'b1 || last_alloc_addr !== 4'(2 - i) || alloc !== 1'b0) begin
                fails++; $display("FAIL pp_dealloc%0d got %b/%0d want 1/%0d", i, de_alloc, last_alloc_addr, 2 - i); end
            if (i < 2) begin
                step(0, 0, 1);
                checks++; if (ready !== 1'b0 || pop_valid !== 1'b0) begin
                    fails++; $display("FAIL pp_refill%0d got ready %b valid %b want 0 0", i, ready, pop_valid); end
                checks++; if (count !== 5'(2 - i)) begin fails++; $display("FAIL pp_rcount%0d got %0d want %0d", i, count, 2 - i); end
            end
        end
        step(0, 0, 0);
        checks++; if (count !== 5'd0 || empty !== 1'b1 || ready !== 1'b1) begin
            fails++; $display("FAIL pp_end got %0d/%b/%b want 0/1/1", count, empty, ready); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            step(1, 32'h1000 + i, 0);
            checks++; if (alloc !== 1'b1) begin fails++; $display("FAIL full_alloc%0d got %b want 1", i, alloc); end
        end
        step(1, 32'hDEAD, 0);
        checks++; if (alloc !== 1'b0) begin fails++; $display("FAIL full_drop_alloc got %b want 0", alloc); end
        checks++; if (full !== 1'b1 || count !== 5'd16) begin
            fails++; $display("FAIL full_flag got %b/%0d want 1/16", full, count); end
        step(0, 0, 0);
        checks++; if (count !== 5'd16 || pop_data !== 32'h100F) begin
            fails++; $display("FAIL full_hold got %0d/%h want 16/100f", count, pop_data); end
        for (int i = 15; i >= 0; i--) begin
            step(0, 0, 1);
            checks++; if (pop_valid !== 1'b1 || pop_data !== 32'h1000 + i) begin
                fails++; $display("FAIL full_pop%0d got %b/%h want 1/%h", i, pop_valid, pop_data, 32'h1000 + i); end
            if (i > 0) step(0, 0, 1);
        end
        step(0, 0, 0);
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin
            fails++; $display("FAIL full_drain got %b/%b want 1/0", empty, full); end
    endtask

    task automatic test_replace();
        step(1, 32'hA, 0);
        step(1, 32'hB, 0);
        step(1, 32'hC, 1);
        checks++; if (pop_valid !== 1'b1 || pop_data !== 32'hB) begin
            fails++; $display("FAIL rep_pop got %b/%h want 1/b", pop_valid, pop_data); end
        checks++; if (alloc !== 1'b0 || de_alloc !== 1'b0) begin
            fails++; $display("FAIL rep_strobes got %b/%b want 0/0", alloc, de_alloc); end
        step(0, 0, 0);
        checks++; if (count !== 5'd2 || ready !== 1'b1 || pop_data !== 32'hC) begin
            fails++; $display("FAIL rep_after got %0d/%b/%h want 2/1/c", count, ready, pop_data); end
        step(0, 0, 1);
        checks++; if (pop_valid !== 1'b1 || pop_data !== 32'hC) begin
            fails++; $display("FAIL rep_pop1 got %b/%h want 1/c", pop_valid, pop_data); end
        step(0, 0, 1);
        step(0, 0, 1);
        checks++; if (pop_valid !== 1'b1 || pop_data !== 32'hA) begin
            fails++; $display("FAIL rep_pop2 got %b/%h want 1/a", pop_valid, pop_data); end
        step(0, 0, 0);
        checks++; if (count !== 5'd0) begin fails++; $display("FAIL rep_end got %0d want 0", count); end
    endtask

    task automatic test_empty();
        step(0, 0, 1);
        checks++; if (pop_valid !== 1'b0 || de_alloc !== 1'b0) begin
            fails++; $display("FAIL emp_pop got %b/%b want 0/0", pop_valid, de_alloc); end
        step(0, 0, 0);
        checks++; if (count !== 5'd0 || ready !== 1'b1) begin
            fails++; $display("FAIL emp_hold got %0d/%b want 0/1", count, ready); end
        step(1, 32'h77, 1);
        checks++; if (alloc !== 1'b1 || pop_valid !== 1'b0 || de_alloc !== 1'b0) begin
            fails++; $display("FAIL emp_pushpop got %b%b%b want 100", alloc, pop_valid, de_alloc); end
        step(0, 0, 0);
        checks++; if (count !== 5'd1 || pop_data !== 32'h77) begin
            fails++; $display("FAIL emp_count got %0d/%h want 1/77", count, pop_data); end
        step(0, 0, 1);
        checks++; if (pop_valid !== 1'b1 || pop_data !== 32'h77) begin
            fails++; $display("FAIL emp_pop1 got %b/%h want 1/77", pop_valid, pop_data); end
        step(0, 0, 0);
        checks++; if (empty !== 1'b1 || ready !== 1'b1) begin
            fails++; $display("FAIL emp_end got %b/%b want 1/1", empty, ready); end
    endtask

    task automatic test_reset_refill();
        int p0;
        step(1, 32'h11, 0);
        step(1, 32'h22, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL rr_inrefill got %b want 0", ready); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 5'd0 || ready !== 1'b0 || alloc_reset !== 1'b0) begin
            fails++; $display("FAIL rr_rst got %0d/%b/%b want 0/0/0", count, ready, alloc_reset); end
        @(negedge clk);
        rst = 1'b0;
        p0 = areset_cnt;
        #1;
        checks++; if (alloc_reset !== 1'b1 || ready !== 1'b0) begin
            fails++; $display("FAIL rr_init got %b/%b want 1/0", alloc_reset, ready); end
        step(0, 0, 0);
        checks++; if (ready !== 1'b1 || count !== 5'd0 || areset_cnt - p0 != 1) begin
            fails++; $display("FAIL rr_idle got %b/%0d/%0d want 1/0/1", ready, count, areset_cnt - p0); end
        step(1, 32'h55, 0);
        checks++; if (alloc !== 1'b1) begin fails++; $display("FAIL rr_push got %b want 1", alloc); end
        step(0, 0, 1);
        checks++; if (pop_valid !== 1'b1 || pop_data !== 32'h55) begin
            fails++; $display("FAIL rr_pop got %b/%h want 1/55", pop_valid, pop_data); end
        step(0, 0, 0);
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL rr_end got %b want 1", empty); end
    endtask

    initial begin
        #2;
        test_reset();
        test_push_pop();
        test_full();
        test_replace();
        test_empty();
        test_reset_refill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not complete");
    end

endmodule
